// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk edges from input change to sync_out.
// Backpressure: none; free-running.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two register stages; both start at RST_VAL so reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= RST_VAL;
            sync_out <= RST_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit midpoint qualification, LSB-first data, stop check.
// Latency: rx_valid / frame_err assert on the edge that samples the stop bit.
// Backpressure: none on the line; an unacked byte is overwritten by the next good frame (overrun pulse).
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bidx, bidx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_nxt;
    logic                 frame_err_nxt;
    logic                 overrun_nxt;
    // Set once the line has been seen idle after reset; a line held low
    // through reset must not be mistaken for a start edge.
    logic                 armed, armed_nxt;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx),
        .sync_out (rx_s)
    );

    assign rx_busy = (state != IDLE);

    // State and datapath registers; everything returns to idle on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bidx      <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bidx      <= bidx_nxt;
            shreg     <= shreg_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
            armed     <= armed_nxt;
        end
    end

    // Next-state logic: FSM/counters move only on tick; ack handling is every cycle.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bidx_nxt      = bidx;
        shreg_nxt     = shreg;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = rx_valid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;
        armed_nxt     = armed;

        if (rx_ack) begin
            rx_valid_nxt = 1'b0;
        end

        if (tick) begin
            case (state)
                IDLE: begin
                    if (rx_s) begin
                        armed_nxt = 1'b1;
                    end else if (armed) begin
                        state_nxt = START;
                        cnt_nxt   = '0;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt_nxt  = '0;
                        bidx_nxt = '0;
                        // Line back high at the midpoint means it was a glitch.
                        state_nxt = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        // LSB arrives first, so shift right and insert at the MSB.
                        shreg_nxt = DATA_BITS'({rx_s, shreg} >> 1);
                        if (bidx == BIDX_LAST) begin
                            bidx_nxt  = '0;
                            state_nxt = STOP;
                        end else begin
                            bidx_nxt = bidx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                        if (rx_s) begin
                            rx_data_nxt  = shreg;
                            rx_valid_nxt = 1'b1;
                            // An ack on this same cycle consumes the old byte, so no loss.
                            overrun_nxt  = rx_valid & ~rx_ack;
                        end else begin
                            frame_err_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written corner sequences.
// Latency: expected bytes are queued at stimulus time and popped when the DUT delivers.
// Backpressure: bench acks explicitly to exercise valid/ack and overrun paths.
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int DW       = 8;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          tick;
    logic          rx_ack;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_busy;
    logic          frame_err;
    logic          overrun;

    int tests   = 0;
    int fails   = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ack;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_err;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[5];

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tick      (tick),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clk tick every TICK_DIV clocks, changed on the falling edge.
    initial begin
        tick = 1'b0;
        forever begin
            for (int k = 0; k < TICK_DIV; k++) begin
                @(negedge clk);
                tick = (k == 0);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts flag pulses and pops the scoreboard on every byte load.
    initial begin
        logic       pv;
        logic [7:0] pd;
        logic [7:0] e;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                pd = '0;
            end else begin
                if (frame_err) err_cnt++;
                if (overrun)   ovr_cnt++;
                if (rx_valid && (!pv || overrun || rx_data != pd)) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected none", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_byte", 32'(rx_data), 32'(e));
                    end
                end
                pv = rx_valid;
                pd = rx_data;
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap_clks);
        if (stop_bit) exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
        repeat (gap_clks) @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int o0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b1, 1, 0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
        vecs[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 0, 1};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 0, 0};

        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_data",   32'(rx_data),   32'h0);
        check("rst_rx_valid",  32'(rx_valid),  32'h0);
        check("rst_rx_busy",   32'(rx_busy),   32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        rst = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);

        // Table-driven frames: good byte, framing error, overrun pair, ack handling.
        for (int i = 0; i < 5; i++) begin
            e0 = err_cnt;
            o0 = ovr_cnt;
            send_frame(vecs[i].d, vecs[i].stop, 8);
            check("vec_rx_data",  32'(rx_data),       32'(vecs[i].exp_data));
            check("vec_rx_valid", 32'(rx_valid),      32'(vecs[i].exp_valid));
            check("vec_err_cnt",  32'(err_cnt - e0),  32'(vecs[i].exp_err));
            check("vec_ovr_cnt",  32'(ovr_cnt - o0),  32'(vecs[i].exp_ovr));
            if (vecs[i].stop) check("vec_idle_busy", 32'(rx_busy), 32'h0);
            if (vecs[i].ack) begin
                ack_pulse();
                check("ack_clears_valid", 32'(rx_valid), 32'h0);
                ack_pulse();
                check("ack_ignored_valid", 32'(rx_valid), 32'h0);
            end
            repeat (2 * BIT_CLKS) @(negedge clk);
        end

        // Short low glitch (4 ticks) is rejected at the start-bit midpoint.
        e0 = err_cnt;
        o0 = ovr_cnt;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy", 32'(rx_busy), 32'h1);
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("glitch_idle",  32'(rx_busy),      32'h0);
        check("glitch_valid", 32'(rx_valid),     32'h0);
        check("glitch_err",   32'(err_cnt - e0), 32'h0);
        check("glitch_ovr",   32'(ovr_cnt - o0), 32'h0);

        // Reset during data bit 3 of 0xFF discards the partial frame.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy",    32'(rx_busy),  32'h0);
        check("midrst_rx_data", 32'(rx_data),  32'h0);
        check("midrst_valid",   32'(rx_valid), 32'h0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6 * BIT_CLKS) @(negedge clk);
        check("midrst_no_output", 32'(rx_valid), 32'h0);
        send_frame(8'h00, 1'b1, 8);
        check("postrst_rx_data", 32'(rx_data),  32'h00);
        check("postrst_valid",   32'(rx_valid), 32'h1);
        ack_pulse();
        repeat (BIT_CLKS) @(negedge clk);

        // Back-to-back frames with no idle gap, acked during the second start bit.
        e0 = err_cnt;
        o0 = ovr_cnt;
        fork
            begin
                send_frame(8'h00, 1'b1, 0);
                send_frame(8'hFF, 1'b1, 8);
            end
            begin
                repeat (10 * BIT_CLKS + 16) @(negedge clk);
                check("b2b_first_valid", 32'(rx_valid), 32'h1);
                check("b2b_first_data",  32'(rx_data),  32'h00);
                ack_pulse();
            end
        join
        check("b2b_rx_data", 32'(rx_data),      32'hFF);
        check("b2b_valid",   32'(rx_valid),     32'h1);
        check("b2b_err",     32'(err_cnt - e0), 32'h0);
        check("b2b_ovr",     32'(ovr_cnt - o0), 32'h0);
        ack_pulse();
        repeat (BIT_CLKS) @(negedge clk);

        check("sb_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: tick pulses per bit period; legal values are even integers from 8 to 32.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, sent LSB first.
REQ-003 Port clk, input, 1: system clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port rx, input, 1: serial line, idle high, asynchronous to clk.
REQ-006 Port tick, input, 1: one-clk-wide enable pulse at OVERSAMPLE x baud rate.
REQ-007 Port rx_data, output, DATA_BITS: last good received byte, held stable until the next good frame.
REQ-008 Port rx_valid, output, 1: high while rx_data holds an unacknowledged byte.
REQ-009 Port rx_ack, input, 1: consumer acknowledge; clears rx_valid.
REQ-010 Port rx_busy, output, 1: high whenever the FSM is not in IDLE.
REQ-011 Port frame_err, output, 1: one-clk pulse when the stop bit is sampled low.
REQ-012 Port overrun, output, 1: one-clk pulse when a good frame overwrites an unacknowledged byte.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; the FSM sees only the synchronized value rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; sample counter cnt ($clog2(OVERSAMPLE) bits) and bit index bidx advance only on cycles with tick=1.
REQ-015 IDLE: on tick with rx_s=0 -> START, cnt=0; otherwise stay.
REQ-016 START: on tick, cnt+1; at cnt=OVERSAMPLE/2-1 (start-bit midpoint), rx_s=0 -> DATA with cnt=0, bidx=0; rx_s=1 -> IDLE (glitch rejected, no flag).
REQ-017 DATA: on tick, cnt+1; at cnt=OVERSAMPLE-1, shift rx_s into shift register MSB (shift right), cnt=0, bidx+1; after bit DATA_BITS-1 -> STOP.
REQ-018 STOP: at cnt=OVERSAMPLE-1 sample rx_s; 1 -> load rx_data from shift register, set rx_valid; 0 -> pulse frame_err, rx_data and rx_valid unchanged; either way -> IDLE.
REQ-019 Frame latency: rx_valid and frame_err SHALL assert on the clk edge that samples the stop bit, with no extra cycle.
REQ-020 rx_ack=1 SHALL clear rx_valid on the next edge; rx_ack while rx_valid=0 SHALL be ignored.
REQ-021 Good frame completing while rx_valid=1 and rx_ack=0: overwrite rx_data, keep rx_valid=1, pulse overrun.
REQ-022 Good frame completing on the same cycle as rx_ack=1: load the new data, rx_valid stays 1, no overrun.
REQ-023 Back-to-back frames: IDLE SHALL accept a new start edge on the first tick after STOP exits.
REQ-024 Cycles with tick=0 SHALL hold all FSM, cnt and bidx state.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, cnt=0, bidx=0, shift register=0, rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, synchronizer=1.
REQ-026 Reset mid-frame SHALL discard the partial frame; after rst deasserts, rx_s must see the line high once before a new start edge is accepted.

Structure
REQ-027 A shared package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, STOP) and the default OVERSAMPLE and DATA_BITS constants used by uart_rx and the transmitter.
REQ-028 The synchronizer SHALL be a separate sub-module, uart_sync2 (1-bit, reset value parameterized), instantiated once.

Verification
REQ-029 Bench: tick every 4 clk, OVERSAMPLE=16; drive 0xA5 as 8N1 -> rx_data=0xA5, rx_valid=1, frame_err=0, overrun=0.
REQ-030 Low glitch on rx of 4 ticks, then idle -> FSM returns to IDLE, rx_valid stays 0, no flags.
REQ-031 Frame 0x3C with stop bit driven 0 -> one frame_err pulse, rx_data keeps its previous value, rx_valid unchanged.
REQ-032 Frames 0x11 then 0x22 with no rx_ack -> one overrun pulse, rx_data=0x22, rx_valid=1; then rx_ack -> rx_valid=0 one edge later.
REQ-033 rst asserted during data bit 3 of 0xFF, then 0x00 sent -> no output for 0xFF, rx_data=0x00 with rx_valid=1.
REQ-034 Back-to-back 0x00 and 0xFF frames with a 1-bit stop and no gap, acked between frames -> both bytes delivered in order, no flags.
